// File: rtl/axi_sim_pkg.sv
// Shared types and helpers for the AXI read-latency responder.
// The widths fix the layout of a queue entry.
package axi_sim_pkg;

  localparam int unsigned AXI_ADDR_BITS            = 16;
  localparam int unsigned AXI_TID_WIDTH            = 8;
  localparam int unsigned AXI_BURST_LEN_WIDTH      = 8;
  localparam int unsigned AXI_LOG_BLOCK_DATA_BYTES = 0;
  localparam int unsigned AXI_LATENCY_WIDTH        = 8;

  typedef struct packed {
    logic [0:AXI_TID_WIDTH-1]       id;
    logic [0:AXI_ADDR_BITS-1]       addr;
    logic [0:AXI_BURST_LEN_WIDTH-1] len;
    logic [0:AXI_LATENCY_WIDTH-1]   countdown;
  } ar_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } rd_state_t;

  // INCR beat address; wraps modulo the address space.
  function automatic logic [0:AXI_ADDR_BITS-1] beat_addr(
    input logic [0:AXI_ADDR_BITS-1]       addr,
    input logic [0:AXI_BURST_LEN_WIDTH-1] k
  );
    return addr + (AXI_ADDR_BITS'(k) << AXI_LOG_BLOCK_DATA_BYTES);
  endfunction

endpackage

// File: rtl/axi_rd_latency_responder_burst_gen.sv
// Streams the R beats of one INCR burst with backpressure.
// done_c pulses combinationally on the last-beat handshake.
module rd_burst_gen
  import axi_sim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  ar_entry_t                entry,
  input  logic                     r_ready,
  output logic                     r_valid,
  output logic [0:DATA_WIDTH-1]    r_data,
  output logic [0:AXI_TID_WIDTH-1] r_id,
  output logic                     r_last,
  output logic                     done_c
);

  logic [0:AXI_ADDR_BITS-1]       base;
  logic [0:AXI_BURST_LEN_WIDTH-1] len;
  logic [0:AXI_BURST_LEN_WIDTH-1] beat;
  logic [0:AXI_BURST_LEN_WIDTH-1] beat_next;
  logic                           handshake;

  assign handshake = r_valid & r_ready;
  assign done_c    = handshake & r_last;
  // Only advanced while beat < len, so it cannot wrap even for the longest burst.
  assign beat_next = beat + AXI_BURST_LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= 1'b0;
      base    <= '0;
      len     <= '0;
      beat    <= '0;
    end else if (load) begin
      base    <= entry.addr;
      len     <= entry.len;
      beat    <= '0;
      r_valid <= 1'b1;
      r_id    <= entry.id;
      r_data  <= DATA_WIDTH'(beat_addr(entry.addr, AXI_BURST_LEN_WIDTH'(0)));
      r_last  <= (entry.len == '0);
    end else if (handshake) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        beat   <= beat_next;
        r_data <= DATA_WIDTH'(beat_addr(base, beat_next));
        r_last <= (beat_next == len);
      end
    end
  end

endmodule

// File: rtl/axi_rd_latency_responder.sv
// AXI4 read responder modelling DRAM: in-order AR queue with per-entry
// latency countdowns feeding a single burst engine.
module axi_rd_latency_responder
  import axi_sim_pkg::*;
#(
  parameter int unsigned ADDR_BITS            = AXI_ADDR_BITS,
  parameter int unsigned TID_WIDTH            = AXI_TID_WIDTH,
  parameter int unsigned BURST_LEN_WIDTH      = AXI_BURST_LEN_WIDTH,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = AXI_LOG_BLOCK_DATA_BYTES,
  parameter int unsigned LOG_QUEUE_SIZE       = 3,
  parameter int unsigned LATENCY_WIDTH        = AXI_LATENCY_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 s_ar_valid,
  output logic                                 s_ar_ready,
  input  logic [0:ADDR_BITS-1]                 s_ar_addr,
  input  logic [0:BURST_LEN_WIDTH-1]           s_ar_len,
  input  logic [0:TID_WIDTH-1]                 s_ar_id,
  output logic                                 s_r_valid,
  input  logic                                 s_r_ready,
  output logic [0:(8<<LOG_BLOCK_DATA_BYTES)-1] s_r_data,
  output logic [0:TID_WIDTH-1]                 s_r_id,
  output logic                                 s_r_last,
  input  logic [0:LATENCY_WIDTH-1]             crs_latency,
  output logic [0:LOG_QUEUE_SIZE]              stat_outstanding
);

  localparam int unsigned DATA_WIDTH  = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int unsigned QUEUE_DEPTH = 1 << LOG_QUEUE_SIZE;
  localparam int unsigned CNT_W       = LOG_QUEUE_SIZE + 1;

  ar_entry_t                 queue_mem [QUEUE_DEPTH];
  ar_entry_t                 head;
  ar_entry_t                 new_entry;
  logic [0:LOG_QUEUE_SIZE-1] wr_ptr;
  logic [0:LOG_QUEUE_SIZE-1] rd_ptr;
  logic [0:CNT_W-1]          count;
  logic [0:CNT_W-1]          count_next;
  rd_state_t                 state;
  rd_state_t                 state_next;
  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      done_c;
  logic [0:AXI_TID_WIDTH-1]  gen_id;

  // Ready ignores a same-cycle pop: a full queue stays closed for that cycle.
  assign full       = (count == CNT_W'(QUEUE_DEPTH));
  assign s_ar_ready = en & ~full & ~rst;
  assign push       = s_ar_valid & s_ar_ready;
  assign head       = queue_mem[rd_ptr];

  always_comb begin
    new_entry           = '0;
    new_entry.id        = AXI_TID_WIDTH'(s_ar_id);
    new_entry.addr      = AXI_ADDR_BITS'(s_ar_addr);
    new_entry.len       = AXI_BURST_LEN_WIDTH'(s_ar_len);
    new_entry.countdown = AXI_LATENCY_WIDTH'(crs_latency);
  end

  // Entry storage: writes on accept, every countdown ages while enabled.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if (push && (wr_ptr == LOG_QUEUE_SIZE'(i))) begin
        queue_mem[i] <= new_entry;
      end else if (en && (queue_mem[i].countdown != '0)) begin
        queue_mem[i].countdown <= queue_mem[i].countdown - AXI_LATENCY_WIDTH'(1);
      end
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Engine FSM next state; the head is popped straight into the burst engine.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE, WAIT: begin
        if (en && (count != '0) && (head.countdown == '0)) begin
          pop        = 1'b1;
          state_next = BURST;
        end else begin
          state_next = ((count != '0) || push) ? WAIT : IDLE;
        end
      end
      BURST: begin
        if (done_c) begin
          state_next = ((count != '0) || push) ? WAIT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      stat_outstanding <= '0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      stat_outstanding <= count_next + CNT_W'(state_next == BURST);
      if (push) wr_ptr <= wr_ptr + LOG_QUEUE_SIZE'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG_QUEUE_SIZE'(1);
    end
  end

  rd_burst_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_burst_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (pop),
    .entry   (head),
    .r_ready (s_r_ready),
    .r_valid (s_r_valid),
    .r_data  (s_r_data),
    .r_id    (gen_id),
    .r_last  (s_r_last),
    .done_c  (done_c)
  );

  assign s_r_id = TID_WIDTH'(gen_id);

endmodule

// File: tb/tb_axi_rd_latency_responder.sv
// Directed self-checking bench for axi_rd_latency_responder (default parameters).
module tb_axi_rd_latency_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        s_ar_valid = 1'b0;
  logic        s_ar_ready;
  logic [0:15] s_ar_addr = '0;
  logic [0:7]  s_ar_len = '0;
  logic [0:7]  s_ar_id = '0;
  logic        s_r_valid;
  logic        s_r_ready = 1'b0;
  logic [0:7]  s_r_data;
  logic [0:7]  s_r_id;
  logic        s_r_last;
  logic [0:7]  crs_latency = '0;
  logic [0:3]  stat_outstanding;

  int n_pass = 0;
  int n_total = 0;

  axi_rd_latency_responder dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .s_ar_valid       (s_ar_valid),
    .s_ar_ready       (s_ar_ready),
    .s_ar_addr        (s_ar_addr),
    .s_ar_len         (s_ar_len),
    .s_ar_id          (s_ar_id),
    .s_r_valid        (s_r_valid),
    .s_r_ready        (s_r_ready),
    .s_r_data         (s_r_data),
    .s_r_id           (s_r_id),
    .s_r_last         (s_r_last),
    .crs_latency      (crs_latency),
    .stat_outstanding (stat_outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one AR and waits (bounded) for its handshake.
  task automatic send_ar(input logic [0:15] addr, input logic [0:7] len,
                         input logic [0:7] id, output bit ok);
    ok         = 1'b0;
    s_ar_valid = 1'b1;
    s_ar_addr  = addr;
    s_ar_len   = len;
    s_ar_id    = id;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (s_ar_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    s_ar_valid = 1'b0;
  endtask

  // Accepts one R beat with ready held high (bounded wait).
  task automatic get_beat(output logic [0:7] data, output logic [0:7] id,
                          output logic last, output bit ok);
    ok        = 1'b0;
    data      = '0;
    id        = '0;
    last      = 1'b0;
    s_r_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (s_r_valid) begin
        data = s_r_data;
        id   = s_r_id;
        last = s_r_last;
        ok   = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; s_ar_valid = 1'b1; s_ar_addr = 16'h1234; s_r_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (s_ar_ready !== 1'b0) $display("FAIL reset_ar_ready c%0d: got %b want 0", c, s_ar_ready); else n_pass++;
      n_total++; if (s_r_valid !== 1'b0) $display("FAIL reset_r_valid c%0d: got %b want 0", c, s_r_valid); else n_pass++;
      n_total++; if (stat_outstanding !== 4'd0) $display("FAIL reset_stat c%0d: got %0d want 0", c, stat_outstanding); else n_pass++;
    end
    rst = 1'b0; s_ar_valid = 1'b0;
    tick();
    n_total++; if (s_ar_ready !== 1'b1) $display("FAIL release_ar_ready: got %b want 1", s_ar_ready); else n_pass++;
    n_total++; if (s_r_last !== 1'b0 || s_r_data !== 8'h00 || s_r_id !== 8'h00) $display("FAIL reset_r_fields: last %b data %h id %h want 0 0 0", s_r_last, s_r_data, s_r_id); else n_pass++;
    en = 1'b0; #1;
    n_total++; if (s_ar_ready !== 1'b0) $display("FAIL en_low_ar_ready: got %b want 0", s_ar_ready); else n_pass++;
    en = 1'b1; #1;
  endtask

  task automatic test_latency();
    bit ok;
    int cnt;
    crs_latency = 8'd5; s_r_ready = 1'b1;
    send_ar(16'h0EEF, 8'd0, 8'd5, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL latency_accept: got %b want 1", ok); else n_pass++;
    n_total++; if (stat_outstanding !== 4'd1) $display("FAIL latency_stat_queued: got %0d want 1", stat_outstanding); else n_pass++;
    cnt = 0;
    while (!s_r_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    n_total++; if (cnt !== 6) $display("FAIL latency_edges: got %0d want 6", cnt); else n_pass++;
    n_total++; if (s_r_data !== 8'hEF) $display("FAIL latency_data: got %h want ef", s_r_data); else n_pass++;
    n_total++; if (s_r_id !== 8'd5) $display("FAIL latency_id: got %0d want 5", s_r_id); else n_pass++;
    n_total++; if (s_r_last !== 1'b1) $display("FAIL latency_last: got %b want 1", s_r_last); else n_pass++;
    tick();
    n_total++; if (s_r_valid !== 1'b0 || stat_outstanding !== 4'd0) $display("FAIL latency_drain: valid %b stat %0d want 0 0", s_r_valid, stat_outstanding); else n_pass++;
  endtask

  task automatic test_burst_wrap();
    bit ok;
    bit bok;
    logic [0:7] d, id;
    logic l;
    logic [0:7] exp_a [4];
    logic [0:7] exp_b [2];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    exp_b[0] = 8'hFF; exp_b[1] = 8'h00;
    crs_latency = 8'd0;
    send_ar(16'h00FE, 8'd3, 8'd7, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL burst_accept: got %b want 1", ok); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      get_beat(d, id, l, bok);
      n_total++; if (bok !== 1'b1 || d !== exp_a[k] || l !== (k == 3)) $display("FAIL burst_beat%0d: ok %b data %h last %b want 1 %h %b", k, bok, d, l, exp_a[k], (k == 3)); else n_pass++;
    end
    n_total++; if (s_r_valid !== 1'b0) $display("FAIL burst_extra_beat: got %b want 0", s_r_valid); else n_pass++;
    send_ar(16'hFFFF, 8'd1, 8'd8, ok);
    for (int k = 0; k < 2; k++) begin
      get_beat(d, id, l, bok);
      n_total++; if (bok !== 1'b1 || d !== exp_b[k] || id !== 8'd8 || l !== (k == 1)) $display("FAIL wrap_beat%0d: ok %b data %h id %0d last %b want 1 %h 8 %b", k, bok, d, id, l, exp_b[k], (k == 1)); else n_pass++;
    end
  endtask

  task automatic test_full_order();
    bit ok;
    logic [0:7] d, id;
    logic l;
    logic rdy [1:10];
    logic [0:7] exp_d;
    s_r_ready = 1'b0; crs_latency = 8'd0;
    for (int i = 1; i <= 10; i++) begin
      s_ar_valid = 1'b1;
      s_ar_addr  = 16'(i << 4);
      s_ar_len   = 8'd0;
      s_ar_id    = 8'(i);
      #1;
      rdy[i] = s_ar_ready;
      tick();
    end
    s_ar_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      n_total++; if (rdy[i] !== (i <= 9)) $display("FAIL full_ready id%0d: got %b want %b", i, rdy[i], (i <= 9)); else n_pass++;
    end
    n_total++; if (stat_outstanding !== 4'd9) $display("FAIL full_stat: got %0d want 9", stat_outstanding); else n_pass++;
    n_total++; if (s_r_valid !== 1'b1 || s_r_id !== 8'd1 || s_r_data !== 8'h10) $display("FAIL full_first: valid %b id %0d data %h want 1 1 10", s_r_valid, s_r_id, s_r_data); else n_pass++;
    s_r_ready = 1'b1;
    tick();
    s_r_ready = 1'b0;
    #1;
    n_total++; if (s_ar_ready !== 1'b0 || stat_outstanding !== 4'd8) $display("FAIL full_after_done: ready %b stat %0d want 0 8", s_ar_ready, stat_outstanding); else n_pass++;
    tick();
    n_total++; if (s_ar_ready !== 1'b1 || stat_outstanding !== 4'd8) $display("FAIL full_after_pop: ready %b stat %0d want 1 8", s_ar_ready, stat_outstanding); else n_pass++;
    for (int i = 2; i <= 9; i++) begin
      get_beat(d, id, l, ok);
      exp_d = 8'(i << 4);
      n_total++; if (ok !== 1'b1 || id !== 8'(i) || d !== exp_d || l !== 1'b1) $display("FAIL order_beat id%0d: ok %b id %0d data %h last %b want 1 %0d %h 1", i, ok, id, d, l, i, exp_d); else n_pass++;
    end
    tick();
    n_total++; if (s_r_valid !== 1'b0 || stat_outstanding !== 4'd0) $display("FAIL order_drain: valid %b stat %0d want 0 0", s_r_valid, stat_outstanding); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int beats;
    bit stalled;
    logic [0:7] hd, hi, exp_d;
    logic hl;
    crs_latency = 8'd2; s_r_ready = 1'b0;
    send_ar(16'h0040, 8'd7, 8'd3, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL bp_accept: got %b want 1", ok); else n_pass++;
    beats = 0; stalled = 1'b0; hd = '0; hi = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 80 && beats < 8; cyc++) begin
      s_r_ready = cyc[0];
      #1;
      if (s_r_valid) begin
        if (stalled) begin
          n_total++; if (s_r_data !== hd || s_r_id !== hi || s_r_last !== hl) $display("FAIL bp_stable beat%0d: data %h id %0d last %b want %h %0d %b", beats, s_r_data, s_r_id, s_r_last, hd, hi, hl); else n_pass++;
        end
        if (s_r_ready) begin
          exp_d = 8'h40 + 8'(beats);
          n_total++; if (s_r_data !== exp_d || s_r_id !== 8'd3 || s_r_last !== (beats == 7)) $display("FAIL bp_beat%0d: data %h id %0d last %b want %h 3 %b", beats, s_r_data, s_r_id, s_r_last, exp_d, (beats == 7)); else n_pass++;
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = s_r_data; hi = s_r_id; hl = s_r_last;
        end
      end
      tick();
    end
    n_total++; if (beats !== 8) $display("FAIL bp_count: got %0d want 8", beats); else n_pass++;
    n_total++; if (s_r_valid !== 1'b0) $display("FAIL bp_extra_beat: got %b want 0", s_r_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    logic [0:7] d, id;
    logic l;
    crs_latency = 8'd0; s_r_ready = 1'b1;
    send_ar(16'h0080, 8'd7, 8'd9, ok);
    get_beat(d, id, l, ok);
    get_beat(d, id, l, ok);
    n_total++; if (s_r_valid !== 1'b1 || s_r_data !== 8'h82) $display("FAIL mid_beat2: valid %b data %h want 1 82", s_r_valid, s_r_data); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (s_r_valid !== 1'b0 || stat_outstanding !== 4'd0) $display("FAIL mid_reset: valid %b stat %0d want 0 0", s_r_valid, stat_outstanding); else n_pass++;
    n_total++; if (s_r_data !== 8'h00 || s_r_last !== 1'b0) $display("FAIL mid_reset_fields: data %h last %b want 00 0", s_r_data, s_r_last); else n_pass++;
    rst = 1'b0;
    tick();
    send_ar(16'h0010, 8'd0, 8'd4, ok);
    get_beat(d, id, l, ok);
    n_total++; if (ok !== 1'b1 || d !== 8'h10 || id !== 8'd4 || l !== 1'b1) $display("FAIL post_reset_beat: ok %b data %h id %0d last %b want 1 10 4 1", ok, d, id, l); else n_pass++;
    n_total++; if (s_r_valid !== 1'b0 || stat_outstanding !== 4'd0) $display("FAIL post_reset_drain: valid %b stat %0d want 0 0", s_r_valid, stat_outstanding); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_burst_wrap();
    test_full_order();
    test_backpressure();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
